// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the iterative radix-2 FFT core
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_e;

  function automatic int bit_rev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      r = r | (((v >> i) & 1) << (bits - 1 - i));
    end
    return r;
  endfunction

  // Only ever called with constant arguments, so the real math folds away at elaboration.
  function automatic int twiddle(input int k, input int n, input int fw, input bit imag_part);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(n);
    v   = imag_part ? -$sin(ang) : $cos(ang);
    return int'($floor(v * real'(1 << fw) + 0.5));
  endfunction

  // a*b - c*d at full precision, then floor-shift back to the working Q format.
  function automatic longint fx_mul_trunc(input longint a, input longint b,
                                          input longint c, input longint d, input int fw);
    return (a * b - c * d) >>> fw;
  endfunction

endpackage

// File: rtl/fft_iter_if.sv
// rtl/fft_iter_if.sv - sample-in / bin-out stream bundle of the iterative FFT core
interface fft_iter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         inv;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_real;
  logic signed [DATA_WIDTH-1:0] in_imag;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_real;
  logic signed [DATA_WIDTH-1:0] out_imag;
  logic                         out_last;

  modport master (
    output inv, in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last
  );

  modport slave (
    input  inv, in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last
  );
endinterface

// File: rtl/fft_twiddle_rom.sv
// rtl/fft_twiddle_rom.sv - constant twiddle table W^k, imaginary part negated for the inverse
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int NFFT        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  localparam int KBITS      = $clog2(NFFT) - 1
) (
  input  logic [KBITS-1:0]             k,
  input  logic                         inv,
  output logic signed [DATA_WIDTH-1:0] w_r,
  output logic signed [DATA_WIDTH-1:0] w_i
);

  logic signed [DATA_WIDTH-1:0] rom_r [NFFT/2];
  logic signed [DATA_WIDTH-1:0] rom_i [NFFT/2];

  for (genvar g = 0; g < NFFT / 2; g++) begin : g_rom
    localparam int WR = twiddle(g, NFFT, FRACT_WIDTH, 1'b0);
    localparam int WI = twiddle(g, NFFT, FRACT_WIDTH, 1'b1);
    assign rom_r[g] = DATA_WIDTH'(WR);
    assign rom_i[g] = DATA_WIDTH'(WI);
  end

  assign w_r = rom_r[k];
  assign w_i = inv ? -rom_i[k] : rom_i[k];

endmodule

// File: rtl/fft_iter.sv
// rtl/fft_iter.sv - iterative in-place radix-2 DIT FFT/IFFT, one butterfly per cycle
// Define FFT_SCALE_EN to halve every butterfly output (overall 1/NFFT scaling).
module fft_iter
  import fft_pkg::*;
#(
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 8,
  parameter int NFFT        = 8,
  localparam int DATA_WIDTH = INT_WIDTH + FRACT_WIDTH,
  localparam int NFFT_BITS  = $clog2(NFFT)
) (
  input  logic        clk,
  input  logic        rst_n,
  fft_iter_if.slave   bus,
  output logic        busy
);

  localparam int KBITS = NFFT_BITS - 1;
  localparam int SBITS = (NFFT_BITS > 1) ? $clog2(NFFT_BITS) : 1;
`ifdef FFT_SCALE_EN
  localparam int SUM_W = DATA_WIDTH + 1;
  localparam int SHIFT = 1;
`else
  localparam int SUM_W = DATA_WIDTH;
  localparam int SHIFT = 0;
`endif

  state_e                 state_q, state_d;
  logic [NFFT_BITS-1:0]   cnt_q, cnt_d;
  logic [KBITS-1:0]       bfly_q, bfly_d;
  logic [SBITS-1:0]       stage_q, stage_d;
  logic                   inv_q, inv_d;

  logic signed [DATA_WIDTH-1:0] mem_r_q [NFFT];
  logic signed [DATA_WIDTH-1:0] mem_i_q [NFFT];

  int                     b_int, s_int, half, i0_int;
  logic [NFFT_BITS-1:0]   idx0, idx1, wr_addr;
  logic [KBITS-1:0]       tw_k;
  logic                   in_fire, bf_en;

  logic signed [DATA_WIDTH-1:0] a_r, a_i, b_r, b_i, w_r, w_i, t_r, t_i;
  logic signed [DATA_WIDTH-1:0] o0_r, o0_i, o1_r, o1_i;
  logic signed [SUM_W-1:0]      s0_r, s0_i, s1_r, s1_i;

  always_comb begin
    b_int   = int'(bfly_q);
    s_int   = int'(stage_q);
    half    = 1 << s_int;
    i0_int  = ((b_int >> s_int) << (s_int + 1)) + (b_int & (half - 1));
    idx0    = NFFT_BITS'(i0_int);
    idx1    = NFFT_BITS'(i0_int + half);
    tw_k    = KBITS'((b_int & (half - 1)) << (NFFT_BITS - 1 - s_int));
    wr_addr = NFFT_BITS'(bit_rev(int'(cnt_q), NFFT_BITS));
  end

  fft_twiddle_rom #(
    .NFFT        (NFFT),
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_rom (
    .k   (tw_k),
    .inv (inv_q),
    .w_r (w_r),
    .w_i (w_i)
  );

  always_comb begin
    a_r  = mem_r_q[idx0];
    a_i  = mem_i_q[idx0];
    b_r  = mem_r_q[idx1];
    b_i  = mem_i_q[idx1];
    t_r  = DATA_WIDTH'(fx_mul_trunc(longint'(b_r), longint'(w_r),
                                    longint'(b_i), longint'(w_i), FRACT_WIDTH));
    t_i  = DATA_WIDTH'(fx_mul_trunc(longint'(b_r), longint'(w_i),
                                    -longint'(b_i), longint'(w_r), FRACT_WIDTH));
    s0_r = SUM_W'(a_r) + SUM_W'(t_r);
    s0_i = SUM_W'(a_i) + SUM_W'(t_i);
    s1_r = SUM_W'(a_r) - SUM_W'(t_r);
    s1_i = SUM_W'(a_i) - SUM_W'(t_i);
    o0_r = DATA_WIDTH'(s0_r >>> SHIFT);
    o0_i = DATA_WIDTH'(s0_i >>> SHIFT);
    o1_r = DATA_WIDTH'(s1_r >>> SHIFT);
    o1_i = DATA_WIDTH'(s1_i >>> SHIFT);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bfly_d        = bfly_q;
    stage_d       = stage_q;
    inv_d         = inv_q;
    in_fire       = 1'b0;
    bf_en         = 1'b0;
    bus.in_ready  = (state_q == LOAD);
    bus.out_valid = (state_q == UNLOAD);
    busy          = (state_q == COMPUTE);
    bus.out_last  = bus.out_valid && (cnt_q == NFFT_BITS'(NFFT - 1));
    bus.out_real  = bus.out_valid ? mem_r_q[cnt_q] : '0;
    bus.out_imag  = bus.out_valid ? mem_i_q[cnt_q] : '0;
    case (state_q)
      LOAD: begin
        in_fire = bus.in_valid;
        if (in_fire) begin
          if (cnt_q == '0) inv_d = bus.inv;
          cnt_d = cnt_q + NFFT_BITS'(1);
          if (cnt_q == NFFT_BITS'(NFFT - 1)) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        bf_en  = 1'b1;
        bfly_d = bfly_q + KBITS'(1);
        if (bfly_q == '1) begin
          stage_d = stage_q + SBITS'(1);
          if (stage_q == SBITS'(NFFT_BITS - 1)) begin
            stage_d = '0;
            state_d = UNLOAD;
          end
        end
      end
      UNLOAD: begin
        if (bus.out_ready) begin
          cnt_d = cnt_q + NFFT_BITS'(1);
          if (cnt_q == NFFT_BITS'(NFFT - 1)) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      bfly_q  <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bfly_q  <= bfly_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
    end
  end

  // Sample memory carries no reset; every frame rewrites all NFFT entries before use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_r_q[wr_addr] <= bus.in_real;
      mem_i_q[wr_addr] <= bus.in_imag;
    end
    if (bf_en) begin
      mem_r_q[idx0] <= o0_r;
      mem_i_q[idx0] <= o0_i;
      mem_r_q[idx1] <= o1_r;
      mem_i_q[idx1] <= o1_i;
    end
  end

endmodule

// File: tb/tb_fft_iter.sv
// tb/tb_fft_iter.sv - scoreboard bench for fft_iter at NFFT=8 and NFFT=64
module tb_fft_iter;
  localparam int DW = 16;
`ifdef FFT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy8, busy64;
  always #5 clk = ~clk;

  fft_iter_if #(.DATA_WIDTH(DW)) if8 ();
  fft_iter_if #(.DATA_WIDTH(DW)) if64 ();

  fft_iter #(.INT_WIDTH(8), .FRACT_WIDTH(8), .NFFT(8))
    u8 (.clk(clk), .rst_n(rst_n), .bus(if8), .busy(busy8));
  fft_iter #(.INT_WIDTH(8), .FRACT_WIDTH(8), .NFFT(64))
    u64 (.clk(clk), .rst_n(rst_n), .bus(if64), .busy(busy64));

  typedef struct { int re; int im; int tol; bit last; bit chk; } exp_t;
  exp_t q8[$];
  exp_t q64[$];
  exp_t e8, e64;
  int cap_r[8], cap_i[8];
  int cap_n = 0;
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int t_last;
  bit stall_out = 1'b0;
  bit holding = 1'b0;
  int hold_r, hold_i, hold_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req, input int tol);
    n_chk++;
    if (act < req - tol || act > req + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if8.out_ready = stall_out ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (if8.out_valid && holding) begin
      check("hold_real", int'(if8.out_real), hold_r, 0);
      check("hold_imag", int'(if8.out_imag), hold_i, 0);
      check("hold_last", int'(if8.out_last), hold_l, 0);
    end
    holding = 1'b0;
    if (if8.out_valid && !if8.out_ready) begin
      holding = 1'b1;
      hold_r  = int'(if8.out_real);
      hold_i  = int'(if8.out_imag);
      hold_l  = int'(if8.out_last);
    end else if (if8.out_valid && if8.out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_out8", 1, 0, 0);
      end else begin
        e8 = q8.pop_front();
        if (e8.chk) begin
          check("bin_real8", int'(if8.out_real), e8.re, e8.tol);
          check("bin_imag8", int'(if8.out_imag), e8.im, e8.tol);
        end
        check("out_last8", int'(if8.out_last), int'(e8.last), 0);
        cap_r[cap_n] = int'(if8.out_real);
        cap_i[cap_n] = int'(if8.out_imag);
        cap_n = (cap_n + 1) % 8;
      end
    end
  end

  always @(negedge clk) begin
    if (if64.out_valid && if64.out_ready) begin
      if (q64.size() == 0) begin
        check("unexpected_out64", 1, 0, 0);
      end else begin
        e64 = q64.pop_front();
        check("bin_real64", int'(if64.out_real), e64.re, e64.tol);
        check("bin_imag64", int'(if64.out_imag), e64.im, e64.tol);
        check("out_last64", int'(if64.out_last), int'(e64.last), 0);
      end
    end
  end

  task automatic push8(input int re[8], input int im[8], input int tol, input bit chk);
    for (int j = 0; j < 8; j++) q8.push_back('{re[j], im[j], tol, j == 7, chk});
  endtask

  task automatic send8(input int re[8], input int im[8], input bit inv_first, input bit gaps);
    int w;
    for (int n = 0; n < 8; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if8.in_valid = 1'b1;
      if8.in_real  = DW'(re[n]);
      if8.in_imag  = DW'(im[n]);
      if8.inv      = (n == 0) ? inv_first : !inv_first;
      w = 0;
      while (!if8.in_ready && w < 2000) begin @(posedge clk); #1; w++; end
      if (w >= 2000) check("in_ready_timeout8", 0, 1, 0);
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
    end
    t_last = cyc;
  endtask

  task automatic wait_out(input string name, input int lat, input int budget, input bit is64);
    int w;
    w = 0;
    while (!(is64 ? if64.out_valid : if8.out_valid) && w < budget) begin @(negedge clk); w++; end
    check(name, cyc - t_last, lat, 0);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((q8.size() > 0 || q64.size() > 0) && w < 3000) begin @(posedge clk); w++; end
    if (w >= 3000) check(name, q8.size() + q64.size(), 0, 0);
    @(posedge clk); #1;
  endtask

  int zero[8], imp[8], dc[8], cosv[8], rt_r[8], rt_i[8];
  int xr[8], xi[8], fb_r[8], fb_i[8];
  int w64;

  initial begin
    zero = '{0, 0, 0, 0, 0, 0, 0, 0};
    imp  = '{256, 0, 0, 0, 0, 0, 0, 0};
    dc   = '{256, 256, 256, 256, 256, 256, 256, 256};
    cosv = '{256, 181, 0, -181, -256, -181, 0, 181};
    rt_r = '{100, -37, 128, 5, -128, 64, -90, 17};
    rt_i = '{-20, 77, -128, 33, 0, -61, 120, -5};
    if8.in_valid = 1'b0; if8.in_real = '0; if8.in_imag = '0; if8.inv = 1'b0; if8.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.in_real = '0; if64.in_imag = '0; if64.inv = 1'b0; if64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(if8.in_ready), 1, 0);
    check("rst_out_valid", int'(if8.out_valid), 0, 0);
    check("rst_out_last", int'(if8.out_last), 0, 0);
    check("rst_busy", int'(busy8), 0, 0);
    check("rst_out_real", int'(if8.out_real), 0, 0);
    check("rst_out_imag", int'(if8.out_imag), 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < 8; j++) xr[j] = SCALE ? 32 : 256;
    push8(xr, zero, 0, 1'b1);
    send8(imp, zero, 1'b0, 1'b0);
    wait_out("latency8", 12, 100, 1'b0);
    drain("drain_impulse");

    xr = zero;
    xr[0] = SCALE ? 256 : 2048;
    push8(xr, zero, 0, 1'b1);
    send8(dc, zero, 1'b0, 1'b0);
    drain("drain_dc");

    // Forward frame with inv raised after the first sample: must stay a forward transform.
    xr = zero;
    xr[1] = SCALE ? 128 : 1024;
    xr[7] = SCALE ? 128 : 1024;
    push8(xr, zero, 2, 1'b1);
    send8(cosv, zero, 1'b0, 1'b0);
    drain("drain_cos");

    stall_out = 1'b1;
    push8(xr, zero, 2, 1'b1);
    send8(cosv, zero, 1'b0, 1'b1);
    drain("drain_stall");
    stall_out = 1'b0;
    @(posedge clk); #1;

    cap_n = 0;
    push8(zero, zero, 0, 1'b0);
    send8(rt_r, rt_i, 1'b0, 1'b0);
    drain("drain_rt_fwd");
    fb_r = cap_r;
    fb_i = cap_i;
    for (int j = 0; j < 8; j++) begin
      xr[j] = SCALE ? rt_r[j] / 8 : rt_r[j] * 8;
      xi[j] = SCALE ? rt_i[j] / 8 : rt_i[j] * 8;
    end
    push8(xr, xi, SCALE ? 2 : 48, 1'b1);
    send8(fb_r, fb_i, 1'b1, 1'b0);
    drain("drain_rt_inv");

    send8(imp, zero, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(if8.in_ready), 1, 0);
    check("abort_out_valid", int'(if8.out_valid), 0, 0);
    check("abort_busy", int'(busy8), 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) xr[j] = SCALE ? 32 : 256;
    push8(xr, zero, 0, 1'b1);
    send8(imp, zero, 1'b0, 1'b0);
    drain("drain_after_abort");

    for (int j = 0; j < 64; j++) q64.push_back('{SCALE ? 4 : 256, 0, 0, j == 63, 1'b1});
    for (int n = 0; n < 64; n++) begin
      if64.in_valid = 1'b1;
      if64.in_real  = (n == 0) ? DW'(256) : '0;
      if64.in_imag  = '0;
      w64 = 0;
      while (!if64.in_ready && w64 < 2000) begin @(posedge clk); #1; w64++; end
      if (w64 >= 2000) check("in_ready_timeout64", 0, 1, 0);
      @(posedge clk); #1;
    end
    if64.in_valid = 1'b0;
    t_last = cyc;
    wait_out("latency64", 192, 400, 1'b1);
    drain("drain_64");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
